// File: rtl/keypad_debounce_fsm.sv
// keypad_debounce_fsm: locks onto the lowest pressed key, debounces press/release, optional auto-repeat
module keypad_debounce_fsm #(
  parameter int NUM_KEYS        = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 5000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_KEYS-1:0]         keys_pressed,
  output logic [NUM_KEYS-1:0]         key_value,
  output logic [$clog2(NUM_KEYS)-1:0] key_index,
  output logic                        new_key,
  output logic                        is_repeat,
  output logic                        key_released,
  output logic                        key_held
);
  localparam int KW   = $clog2(NUM_KEYS);
  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [CW-1:0] D_M1  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_M1 = RW'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_M1 = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE_PRESS, HELD, DEBOUNCE_RELEASE} state_t;

  state_t              state, state_n;
  logic [NUM_KEYS-1:0] cand, cand_n, kv_n, lowest;
  logic [KW-1:0]       cidx, ki_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [RW-1:0]       rcnt, rcnt_n;
  logic                rep, rep_n, hit, nk_n, ir_n, kr_n, kh_n;

  assign lowest = keys_pressed & (~keys_pressed + NUM_KEYS'(1));
  assign hit    = |(keys_pressed & cand);

  always_comb begin
    cidx = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (cand[i]) cidx = KW'(i);
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    rcnt_n  = rcnt;
    rep_n   = rep;
    kv_n    = key_value;
    ki_n    = key_index;
    nk_n    = 1'b0;
    ir_n    = 1'b0;
    kr_n    = 1'b0;
    case (state)
      IDLE:
        if (|keys_pressed) begin
          cand_n  = lowest;
          cnt_n   = '0;
          state_n = DEBOUNCE_PRESS;
        end
      DEBOUNCE_PRESS:
        if (!hit) state_n = IDLE;
        else if (cnt == D_M1) begin
          state_n = HELD;
          kv_n    = cand;
          ki_n    = cidx;
          nk_n    = 1'b1;
          rcnt_n  = '0;
          rep_n   = 1'b0;
        end else cnt_n = cnt + CW'(1);
      HELD:
        if (!hit) begin
          cnt_n   = '0;
          state_n = DEBOUNCE_RELEASE;
        end else if (REPEAT_DELAY != 0) begin
          // first repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD
          if (rcnt == (rep ? RP_M1 : RD_M1)) begin
            nk_n   = 1'b1;
            ir_n   = 1'b1;
            rcnt_n = '0;
            rep_n  = 1'b1;
          end else rcnt_n = rcnt + RW'(1);
        end
      default:
        if (hit) state_n = HELD;
        else if (cnt == D_M1) begin
          state_n = IDLE;
          kr_n    = 1'b1;
        end else cnt_n = cnt + CW'(1);
    endcase
    kh_n = (state_n == HELD) || (state_n == DEBOUNCE_RELEASE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cand         <= '0;
      cnt          <= '0;
      rcnt         <= '0;
      rep          <= 1'b0;
      key_value    <= '0;
      key_index    <= '0;
      new_key      <= 1'b0;
      is_repeat    <= 1'b0;
      key_released <= 1'b0;
      key_held     <= 1'b0;
    end else begin
      state        <= state_n;
      cand         <= cand_n;
      cnt          <= cnt_n;
      rcnt         <= rcnt_n;
      rep          <= rep_n;
      key_value    <= kv_n;
      key_index    <= ki_n;
      new_key      <= nk_n;
      is_repeat    <= ir_n;
      key_released <= kr_n;
      key_held     <= kh_n;
    end
  end
endmodule

// File: tb/tb_keypad_debounce_fsm.sv
// tb_keypad_debounce_fsm: directed keypad scenarios checked against an event-counting model every cycle
module tb_keypad_debounce_fsm;
  localparam int N = 16, D = 4, RD = 10, RP = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] keys = '0;
  logic [N-1:0] key_value, k0_value;
  logic [3:0]   key_index, k0_index;
  logic         new_key, is_repeat, key_released, key_held;
  logic         k0_new, k0_rep, k0_rel, k0_held;
  int checks = 0, failures = 0;

  keypad_debounce_fsm #(.NUM_KEYS(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .reset(reset), .keys_pressed(keys), .key_value(key_value), .key_index(key_index),
    .new_key(new_key), .is_repeat(is_repeat), .key_released(key_released), .key_held(key_held));

  keypad_debounce_fsm #(.NUM_KEYS(N), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)) dut0 (
    .clk(clk), .reset(reset), .keys_pressed(keys), .key_value(k0_value), .key_index(k0_index),
    .new_key(k0_new), .is_repeat(k0_rep), .key_released(k0_rel), .key_held(k0_held));

  always #5 clk = ~clk;

  // model: cand<0 means nothing locked; run/rl count consecutive good samples, hk counts held samples
  int cand = -1, run = 0, hk = 0, rl = 0;
  bit down = 0, rel_ph = 0, e_nk = 0, e_rep = 0, e_rel = 0;
  logic [N-1:0] e_kv = '0;
  logic [3:0]   e_ki = '0;

  function automatic int lowest(input logic [N-1:0] k);
    for (int i = 0; i < N; i++) if (k[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    e_nk = 0; e_rep = 0; e_rel = 0;
    if (reset) begin
      cand = -1; down = 0; rel_ph = 0; e_kv = '0; e_ki = '0; run = 0; hk = 0; rl = 0;
    end else if (cand < 0) begin
      if (keys != '0) begin cand = lowest(keys); run = 0; end
    end else if (!down) begin
      if (!keys[cand]) cand = -1;
      else begin
        run++;
        if (run == D) begin down = 1; hk = 0; e_nk = 1; e_kv = N'(1) << cand; e_ki = 4'(cand); end
      end
    end else if (!rel_ph) begin
      if (keys[cand]) begin
        hk++;
        if (hk >= RD && (hk - RD) % RP == 0) begin e_nk = 1; e_rep = 1; end
      end else begin rel_ph = 1; rl = 0; end
    end else if (keys[cand]) rel_ph = 0;
    else begin
      rl++;
      if (rl == D) begin e_rel = 1; down = 0; rel_ph = 0; cand = -1; end
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({key_value, key_index, new_key, is_repeat, key_released, key_held} !== {e_kv, e_ki, e_nk, e_rep, e_rel, down}) begin
      failures++;
      $display("FAIL model_main t=%0t got kv=%h ki=%0d nk=%b rep=%b rel=%b held=%b exp kv=%h ki=%0d nk=%b rep=%b rel=%b held=%b",
               $time, key_value, key_index, new_key, is_repeat, key_released, key_held, e_kv, e_ki, e_nk, e_rep, e_rel, down);
    end
    checks++;
    if ({k0_value, k0_index, k0_new, k0_rep, k0_rel, k0_held} !== {e_kv, e_ki, e_nk & ~e_rep, 1'b0, e_rel, down}) begin
      failures++;
      $display("FAIL model_norep t=%0t got kv=%h ki=%0d nk=%b rep=%b rel=%b held=%b exp kv=%h ki=%0d nk=%b rep=0 rel=%b held=%b",
               $time, k0_value, k0_index, k0_new, k0_rep, k0_rel, k0_held, e_kv, e_ki, e_nk & ~e_rep, e_rel, down);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    w(3);
    chk("rst_kv", 32'(key_value), 0); chk("rst_ki", 32'(key_index), 0);
    chk("rst_nk", 32'(new_key), 0); chk("rst_held", 32'(key_held), 0);
    reset = 1'b0;
    w(1);
    // clean press and release of key 5
    keys = 16'h0020; w(4); chk("press_early", 32'(new_key), 0);
    w(1); chk("press_nk", 32'(new_key), 1); chk("press_kv", 32'(key_value), 32'h20);
    chk("press_ki", 32'(key_index), 5); chk("press_held", 32'(key_held), 1); chk("press_rep", 32'(is_repeat), 0);
    w(1); chk("press_one", 32'(new_key), 0);
    keys = '0; w(4); chk("rel_early", 32'(key_released), 0);
    w(1); chk("rel_pulse", 32'(key_released), 1); chk("rel_held", 32'(key_held), 0); chk("rel_kv", 32'(key_value), 32'h20);
    w(1); chk("rel_one", 32'(key_released), 0);
    // bounce on key 5
    keys = 16'h0020; w(2); keys = '0; w(1); keys = 16'h0020;
    w(4); chk("bounce_early", 32'(new_key), 0);
    w(1); chk("bounce_nk", 32'(new_key), 1); chk("bounce_ki", 32'(key_index), 5);
    keys = '0; w(7);
    // simultaneous keys 4 and 7, release glitch, then real release
    keys = 16'h0090; w(5); chk("sim_nk", 32'(new_key), 1); chk("sim_kv", 32'(key_value), 32'h10); chk("sim_ki", 32'(key_index), 4);
    w(1); keys = 16'h0080; w(2); chk("glitch_held", 32'(key_held), 1); chk("glitch_rel", 32'(key_released), 0);
    keys = 16'h0090; w(2); chk("glitch_back", 32'(key_held), 1);
    keys = 16'h0080; w(4); chk("k4_rel_early", 32'(key_released), 0);
    w(1); chk("k4_rel", 32'(key_released), 1); chk("k4_held", 32'(key_held), 0); chk("k4_kv", 32'(key_value), 32'h10);
    w(5); chk("k7_nk", 32'(new_key), 1); chk("k7_ki", 32'(key_index), 7); chk("k7_kv", 32'(key_value), 32'h80);
    keys = '0; w(7);
    // auto-repeat on key 0
    keys = 16'h0001; w(5); chk("ar_nk", 32'(new_key), 1); chk("ar_ki", 32'(key_index), 0);
    for (int k = 1; k <= 30; k++) begin
      w(1);
      chk($sformatf("ar_nk_%0d", k), 32'(new_key), 32'(k >= 10 && (k - 10) % 3 == 0));
      chk($sformatf("ar_rep_%0d", k), 32'(is_repeat), 32'(k >= 10 && (k - 10) % 3 == 0));
      chk($sformatf("ar0_nk_%0d", k), 32'(k0_new), 0);
    end
    keys = '0; w(7);
    // asynchronous reset mid-debounce of key 2
    keys = 16'h0004; w(2); #2 reset = 1'b1; #1;
    chk("arst_kv", 32'(key_value), 0); chk("arst_k0kv", 32'(k0_value), 0); chk("arst_held", 32'(key_held), 0);
    @(negedge clk); reset = 1'b0;
    w(4); chk("arst_early", 32'(new_key), 0);
    w(1); chk("arst_nk", 32'(new_key), 1); chk("arst_ki", 32'(key_index), 2);
    keys = '0; w(7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/keypad_debounce_fsm.md
# keypad_debounce_fsm

Parametrised keypad debouncer for the FPGA keypad path. It takes the synchronised raw key vector from the scanner and locks onto a single key. It reports debounced press and release events, and can optionally generate timed auto-repeat events. Its outputs feed the display and entry logic with one-cycle strobes.

## Interface
- NUM_KEYS, 16: width of the raw key vector; ≥2.
- DEBOUNCE_CYCLES, 50000: stable-sample count D for press and release; ≥1.
- REPEAT_DELAY, 0: HELD cycles before the first auto-repeat; 0 disables auto-repeat.
- REPEAT_PERIOD, 5000: cycles between subsequent repeats; ≥1.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- keys_pressed  in  NUM_KEYS  raw key levels, already synchronised to clk; bit i high = key i down.
- key_value  out  NUM_KEYS  one-hot of the last debounced key; holds after release.
- key_index  out  $clog2(NUM_KEYS)  binary index of key_value.
- new_key  out  1  one-cycle strobe on a debounced press or an auto-repeat.
- is_repeat  out  1  high only in the same cycle as a repeat-generated new_key.
- key_released  out  1  one-cycle strobe on a debounced release.
- key_held  out  1  high in HELD and DEBOUNCE_RELEASE.

## Operation
- All outputs are registered. Reset values are 0 for every output; state resets to IDLE and all counters to 0.
- Internal state: candidate one-hot register, debounce counter cnt (width $clog2(DEBOUNCE_CYCLES+1)), repeat counter rcnt (wide enough for max(REPEAT_DELAY, REPEAT_PERIOD)).
- IDLE
  - If keys_pressed≠0: capture candidate = lowest-index set bit, set cnt=0, go to DEBOUNCE_PRESS.
- DEBOUNCE_PRESS
  - If keys_pressed & candidate is 0: go to IDLE (no output).
  - Else if cnt==D-1: go to HELD; load key_value/key_index from candidate; pulse new_key; set rcnt=0.
  - Else cnt++.
- HELD
  - If the candidate bit is low: set cnt=0, go to DEBOUNCE_RELEASE.
  - Else, if REPEAT_DELAY≠0: rcnt++.
    - When rcnt reaches REPEAT_DELAY-1 for the first repeat, or REPEAT_PERIOD-1 for later repeats: pulse new_key and is_repeat, reset rcnt=0.
- DEBOUNCE_RELEASE
  - If the candidate bit is high: return to HELD. rcnt stays frozen; no new event.
  - Else if cnt==D-1: go to IDLE, pulse key_released, clear key_held.
  - Else cnt++.
- Keys other than the candidate are ignored in every non-IDLE state.
- If the candidate drops while another key rises in DEBOUNCE_PRESS, the block returns to IDLE. The other key is captured on the next edge.
- key_value/key_index change only on entry to HELD.

## Timing
- Let E0 be the edge that samples a press in IDLE. If the candidate is sampled high at E0..E_D, new_key is high in the cycle after E_D. Press latency is D+1 edges from E0.
- Release: the first low sample moves the block to DEBOUNCE_RELEASE at edge R0. key_released is high after edge R_D if the key is low at R0..R_D.
- First repeat: new_key is high after edge E_D+REPEAT_DELAY (when no release glitch occurs). Each later repeat follows REPEAT_PERIOD edges after the previous one.
- A repeat and a release never coincide, because repeats fire only in HELD.
- new_key, is_repeat and key_released are exactly one cycle wide and are never high in the same cycle as each other, except the new_key+is_repeat pair.
- Reset asserted mid-operation clears all outputs immediately, without a clock edge. A key still down after reset deasserts is debounced as a fresh press from IDLE.

## Test plan
Bench parameters: NUM_KEYS=16, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Clean press: keys_pressed=16'h0020 held. Response: exactly one new_key, 5 edges after the capture edge; key_value=16'h0020, key_index=5, key_held=1, is_repeat=0.
- Bounce: key 5 high for 2 cycles, low for 1, then stable high. Response: no event during the bounce; a single new_key 5 edges after the recapture edge.
- Simultaneous keys: keys_pressed=16'h0090. Response: key 4 wins, key_value=16'h0010, key_index=4. Releasing key 4 while key 7 stays down gives key_released, then a fresh debounced new_key for key 7 (key_index=7).
- Release glitch then release: with key 4 held, drop it for 2 cycles then raise it. Response: no key_released, key_held stays 1. Then drop it for ≥5 cycles. Response: one key_released pulse, key_held=0, key_value stays 16'h0010.
- Auto-repeat: hold key 0 for 30 cycles after the initial new_key. Response: repeats at +10, +13, +16, … edges, each with is_repeat=1. Rebuild with REPEAT_DELAY=0: no repeats.
- Async reset: assert reset between clock edges mid-DEBOUNCE_PRESS. Response: all outputs go to 0 immediately. Keep the key held through deassertion; new_key appears 5 edges after the first post-reset capture edge.
